// File: rtl/seqdet_pkg.sv
// seqdet_pkg
// Shared definitions for the serial pattern detector:
//   state_t      - detector FSM encoding (history still filling / fully armed)
//   sat_inc()    - saturating increment used by the fill and match counters
//   DEF_PAT_W    - default pattern length
//   DEF_PATTERN  - default pattern (MSB is the oldest bit), also used by benches
package seqdet_pkg;

  typedef enum logic {
    ST_FILLING = 1'b0,
    ST_ARMED   = 1'b1
  } state_t;

  localparam int              DEF_PAT_W   = 7;
  localparam logic [6:0]      DEF_PATTERN = 7'b1011001;

  // Returns v+1, or v unchanged once it has reached max_v.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_detector.sv
// seq_detector
// Serial bit-pattern detector. One bit is taken per clock while i_en is high;
// o_val pulses for one cycle after the edge at which the most recent PAT_W
// bits equal the active pattern. The pattern and overlap mode can be replaced
// at runtime (i_load), and matches are tallied in a saturating counter.
//
// Ports:
//   clk      system clock
//   rst      synchronous reset, active high (restores pattern/mode defaults)
//   i_en     bit strobe; i_val is sampled only when high
//   i_val    serial data bit
//   i_clr    synchronous clear of history, fill, counter and o_val
//   i_load   load i_pat / i_ovl as the active configuration, restart filling
//   i_pat    new pattern value (MSB = oldest bit)
//   i_ovl    new overlap mode (1 = overlapping matches allowed)
//   o_val    one-cycle match pulse, registered
//   o_cnt    saturating match count
//   o_armed  history holds PAT_W valid bits
module seq_detector
  import seqdet_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_val,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [PAT_W-1:0] i_pat,
  input  logic             i_ovl,
  output logic             o_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_armed
);

  // Only PAT_W-1 past bits are stored: the newest bit of a match is i_val
  // itself, so the oldest history bit would never be looked at.
  localparam int HIST_W = PAT_W - 1;
  localparam int FILL_W = $clog2(PAT_W + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_PRE  = FILL_W'(PAT_W - 1);

  logic [HIST_W-1:0] hist_reg, hist_next;
  logic [FILL_W-1:0] fill_reg, fill_next;
  logic [PAT_W-1:0]  pat_reg,  pat_next;
  logic              ovl_reg,  ovl_next;
  logic              val_reg,  val_next;
  logic [CNT_W-1:0]  cnt_reg,  cnt_next;
  state_t            state_reg, state_next;
  logic              hit;

  // A match needs PAT_W-1 valid stored bits plus the bit arriving now.
  always_comb begin
    hit = i_en && (fill_reg >= FILL_PRE) && ({hist_reg, i_val} == pat_reg);
  end

  always_comb begin
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    pat_next   = pat_reg;
    ovl_next   = ovl_reg;
    cnt_next   = cnt_reg;
    val_next   = 1'b0;

    if (i_clr) begin
      hist_next = '0;
      fill_next = '0;
      cnt_next  = '0;
    end else if (i_load) begin
      // The bit presented alongside a load is dropped; filling restarts.
      pat_next  = i_pat;
      ovl_next  = i_ovl;
      fill_next = '0;
    end else if (i_en) begin
      hist_next = HIST_W'({hist_reg, i_val});
      fill_next = FILL_W'(sat_inc(32'(fill_reg), 32'(PAT_W)));
      if (hit) begin
        val_next = 1'b1;
        cnt_next = CNT_W'(sat_inc(32'(cnt_reg), 32'({CNT_W{1'b1}})));
        // Non-overlap: forget everything so the next match needs PAT_W fresh bits.
        if (!ovl_reg) begin
          fill_next = '0;
        end
      end
    end

    state_next = (fill_next == FILL_FULL) ? ST_ARMED : ST_FILLING;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg  <= '0;
      fill_reg  <= '0;
      pat_reg   <= PATTERN;
      ovl_reg   <= OVERLAP;
      val_reg   <= 1'b0;
      cnt_reg   <= '0;
      state_reg <= ST_FILLING;
    end else begin
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      pat_reg   <= pat_next;
      ovl_reg   <= ovl_next;
      val_reg   <= val_next;
      cnt_reg   <= cnt_next;
      state_reg <= state_next;
    end
  end

  assign o_val   = val_reg;
  assign o_cnt   = cnt_reg;
  assign o_armed = (state_reg == ST_ARMED);

endmodule
